// File: rtl/uart_pkg.sv
// Shared encodings for the parametrised UART transmitter: parity modes, FSM
// state codes and the baud divisor helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Clocks per bit; truncates so the line runs marginally fast, never slow.
    function automatic int calc_div(input longint clk_freq, input longint baud);
        return int'(clk_freq / baud);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock word FIFO in front of the UART framer; pop data is combinational from the head.
// A push while full is taken only when a pop frees the slot in the same cycle; flush empties it.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (start, DATA_BITS LSB first, optional parity, 1-2 stops); tx low 1 clk after accept.
// Accepts via valid/ready only while idle, or into a FIFO_DEPTH queue when UART_TX_FIFO_EN is defined.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int              DIV       = calc_div(CLK_FREQ, BAUD);
    localparam int              CW        = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   CNT_TOP   = CW'(DIV - 1);
    localparam int              BW        = $clog2(DATA_BITS);
    localparam logic [BW-1:0]   BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic            STOP_LAST = (STOP_BITS == 2);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 par_bit;
    logic                 start;
    logic [DATA_BITS-1:0] start_data;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_ODD) ? ~^d : ^d;
    endfunction

`ifdef UART_TX_FIFO_EN
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_data;

    // A pop in the same cycle frees a slot, so a full queue can still take a word.
    assign fifo_pop   = tx_en & ~rst & (state == ST_IDLE) & ~fifo_empty;
    assign in_ready   = tx_en & ~rst & (~fifo_full | fifo_pop);
    assign start      = fifo_pop;
    assign start_data = fifo_data;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (~tx_en),
        .push      (in_valid & in_ready),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
`else
    assign in_ready   = tx_en & ~rst & (state == ST_IDLE);
    assign start      = in_valid & in_ready;
    assign start_data = in_data;
`endif

    always_ff @(posedge clk) begin
        if (rst || !tx_en) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    shreg    <= start_data;
                    par_bit  <= parity_of(start_data);
                    cnt      <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    state    <= ST_START;
                    tx       <= 1'b0;
                    tx_busy  <= 1'b1;
                end
            end else if (cnt != CNT_TOP) begin
                cnt <= cnt + 1'b1;
            end else begin
                // Terminal count: the next bit goes onto the line at this edge.
                cnt <= '0;
                case (state)
                    ST_START: begin
                        state <= ST_DATA;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                    ST_DATA: begin
                        if (bit_idx == BIT_LAST) begin
                            if (PARITY != PAR_NONE) begin
                                state <= ST_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                    ST_STOP: begin
                        if (stop_idx == STOP_LAST) begin
                            state   <= ST_IDLE;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (8N1, 7E2, 7O2) at DIV=16 against a frame-level model.
module tb_uart_tx_param;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       vld  [3];
    logic [8:0] dat  [3];
    logic       txo  [3];
    logic       busy [3];
    logic       done [3];
    logic       rdy  [3];
    bit         chk_on = 1'b0;

    int cyc_chk = 0, cyc_pass = 0;
    int lit_chk = 0, lit_pass = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_data(dat[0][7:0]), .tx(txo[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_data(dat[1][6:0]), .tx(txo[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .in_valid(vld[2]), .in_ready(rdy[2]),
        .in_data(dat[2][6:0]), .tx(txo[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    // ---------------- frame-level model ----------------
    bit        m_act  [3];
    int        m_pos  [3];
    int        m_len  [3];
    bit [15:0] m_fb   [3];
    bit        m_done [3];
`ifdef UART_TX_FIFO_EN
    logic [8:0] mq  [3][4];
    int         mqn [3];
`endif

    function automatic int db_of(int g);  return (g == 0) ? 8 : 7; endfunction
    function automatic int par_of(int g); return (g == 0) ? 0 : ((g == 1) ? 2 : 1); endfunction
    function automatic int sb_of(int g);  return (g == 0) ? 1 : 2; endfunction

    function automatic int nbits(int g);
        return 1 + db_of(g) + ((par_of(g) != 0) ? 1 : 0) + sb_of(g);
    endfunction

    // Line bits in transmit order; positions past the frame are mark.
    function automatic bit [15:0] build(int g, logic [8:0] d);
        bit [15:0] f;
        int ones, n;
        f = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < db_of(g); i++) begin
            f[1 + i] = d[i];
            ones += int'(d[i]);
        end
        n = 1 + db_of(g);
        if (par_of(g) == 2) f[n] = (ones % 2 == 1);
        if (par_of(g) == 1) f[n] = (ones % 2 == 0);
        return f;
    endfunction

    function automatic bit mrdy(int g);
`ifdef UART_TX_FIFO_EN
        return tx_en && !rst && (mqn[g] < 4 || (!m_act[g] && mqn[g] > 0));
`else
        return tx_en && !rst && !m_act[g];
`endif
    endfunction

    task automatic m_start(int g, logic [8:0] d);
        m_act[g] = 1'b1;
        m_pos[g] = 0;
        m_fb[g]  = build(g, d);
        m_len[g] = nbits(g) * DIV;
    endtask

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            bit r;
            r = mrdy(g);
            m_done[g] = 1'b0;
            if (rst || !tx_en) begin
                m_act[g] = 1'b0;
`ifdef UART_TX_FIFO_EN
                mqn[g] = 0;
`endif
            end else begin
                if (m_act[g]) begin
                    m_pos[g]++;
                    if (m_pos[g] == m_len[g]) begin
                        m_act[g]  = 1'b0;
                        m_done[g] = 1'b1;
                    end
                end
`ifdef UART_TX_FIFO_EN
                else if (mqn[g] > 0) begin
                    m_start(g, mq[g][0]);
                    for (int k = 0; k < 3; k++) mq[g][k] = mq[g][k + 1];
                    mqn[g]--;
                end
                if (vld[g] && r) begin
                    mq[g][mqn[g]] = dat[g];
                    mqn[g]++;
                end
`else
                else if (vld[g] && r) m_start(g, dat[g]);
`endif
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            for (int g = 0; g < 3; g++) begin
                logic [3:0] got, exp;
                got = {txo[g], busy[g], done[g], rdy[g]};
                exp = {m_act[g] ? m_fb[g][m_pos[g] / DIV] : 1'b1, m_act[g], m_done[g], mrdy(g)};
                cyc_chk++;
                if (got === exp) cyc_pass++;
                else $display("FAIL cycle_u%0d t=%0t tx/busy/done/rdy got %b expected %b", g, $time, got, exp);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic lit(string name, logic got, logic exp);
        lit_chk++;
        if (got === exp) lit_pass++;
        else $display("FAIL %s t=%0t got %b expected %b", name, $time, got, exp);
    endtask

    task automatic send(int g, logic [8:0] d, bit keep);
        bit ok;
        ok = 1'b0;
        dat[g] = d;
        vld[g] = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            ok = mrdy(g);
            @(posedge clk);
            #2;
        end
        if (!keep) vld[g] = 1'b0;
        if (!ok) begin
            lit_chk++;
            $display("FAIL accept_timeout u%0d data %h not accepted", g, d);
        end
    endtask

    logic [9:0] t1_exp;
    bit         saw_done;
    int         n_done;

    initial begin
        rst   = 1'b1;
        tx_en = 1'b1;
        for (int g = 0; g < 3; g++) begin
            vld[g] = 1'b0;
            dat[g] = '0;
        end
        @(posedge clk);
        #2 chk_on = 1'b1;
        @(negedge clk);
        lit("rst_tx", txo[0], 1'b1);
        lit("rst_busy", busy[0], 1'b0);
        lit("rst_done", done[0], 1'b0);
        lit("rst_rdy", rdy[0], 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        lit("idle_rdy", rdy[0], 1'b1);

        // 1: 0xA5 8N1, line 0,1,0,1,0,0,1,0,1,1
        t1_exp = 10'b11_0100_1010;
        send(0, 9'h0A5, 1'b0);
        for (int c = 0; c <= 170; c++) begin
            @(negedge clk);
            if (c % 16 == 8 && c < 160) lit("t1_bit", txo[0], t1_exp[c / 16]);
            if (c == 80)  lit("t1_rdy_busy", rdy[0], 1'b0);
            if (c == 159) lit("t1_done_early", done[0], 1'b0);
            if (c == 160) begin
                lit("t1_done", done[0], 1'b1);
                lit("t1_busy_end", busy[0], 1'b0);
            end
            if (c == 161) lit("t1_done_pulse", done[0], 1'b0);
        end

        // 2: 0x35 on 7E2 (parity 0) and 7O2 (parity 1), 176-clk frames
        dat[2] = 9'h035;
        vld[2] = 1'b1;
        send(1, 9'h035, 1'b0);
        vld[2] = 1'b0;
        for (int c = 0; c <= 178; c++) begin
            @(negedge clk);
            if (c == 24)  lit("t2_d0", txo[1], 1'b1);
            if (c == 136) begin
                lit("t2_par_even", txo[1], 1'b0);
                lit("t2_par_odd", txo[2], 1'b1);
            end
            if (c == 168) lit("t2_stop2", txo[1], 1'b1);
            if (c == 175) lit("t2_done_early", done[1], 1'b0);
            if (c == 176) begin
                lit("t2_done_e", done[1], 1'b1);
                lit("t2_done_o", done[2], 1'b1);
            end
        end

        // 3: back-to-back 0x01 then 0x02 with valid held
        send(0, 9'h001, 1'b1);
        dat[0] = 9'h002;
        for (int c = 0; c <= 322; c++) begin
            @(negedge clk);
            if (c == 160) begin
                lit("t3_gap_tx", txo[0], 1'b1);
                lit("t3_gap_done", done[0], 1'b1);
                lit("t3_gap_rdy", rdy[0], 1'b1);
                @(posedge clk);
                #2 vld[0] = 1'b0;
            end
            if (c == 161) begin
                lit("t3_start2", txo[0], 1'b0);
                lit("t3_busy2", busy[0], 1'b1);
            end
            if (c == 185) lit("t3_w2_d0", txo[0], 1'b0);
            if (c == 201) lit("t3_w2_d1", txo[0], 1'b1);
            if (c == 321) lit("t3_done2", done[0], 1'b1);
        end

        // 4: abort with tx_en at clk 50
        saw_done = 1'b0;
        send(0, 9'h03C, 1'b0);
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            if (c > 50 && done[0] === 1'b1) saw_done = 1'b1;
            if (c == 50) #1 tx_en = 1'b0;
            if (c == 51) begin
                lit("t4_tx_idle", txo[0], 1'b1);
                lit("t4_busy", busy[0], 1'b0);
                lit("t4_rdy_off", rdy[0], 1'b0);
            end
            if (c == 54) #1 tx_en = 1'b1;
            if (c == 55) lit("t4_rdy_back", rdy[0], 1'b1);
        end
        lit("t4_no_done", saw_done, 1'b0);

        // 5: reset mid-DATA, then a full 0xFF frame
        send(0, 9'h05A, 1'b0);
        for (int c = 0; c <= 45; c++) begin
            @(negedge clk);
            if (c == 40) #1 rst = 1'b1;
            if (c == 41) begin
                lit("t5_tx", txo[0], 1'b1);
                lit("t5_busy", busy[0], 1'b0);
                lit("t5_done", done[0], 1'b0);
                lit("t5_rdy", rdy[0], 1'b0);
                #1 rst = 1'b0;
            end
        end
        send(0, 9'h0FF, 1'b0);
        for (int c = 0; c <= 161; c++) begin
            @(negedge clk);
            if (c % 16 == 8 && c < 160) lit("t5_ff_bit", txo[0], logic'(c >= 16));
            if (c == 160) lit("t5_ff_done", done[0], 1'b1);
        end

`ifdef UART_TX_FIFO_EN
        // 6: queue five words, then a sixth that lands on a full-queue pop
        send(0, 9'h011, 1'b1);
        send(0, 9'h022, 1'b1);
        send(0, 9'h033, 1'b1);
        send(0, 9'h044, 1'b1);
        send(0, 9'h055, 1'b1);
        lit("t6_full_rdy", rdy[0], 1'b0);
        send(0, 9'h066, 1'b0);
        n_done = 0;
        for (int c = 0; c < 1000 && n_done < 5; c++) begin
            @(negedge clk);
            if (done[0] === 1'b1) n_done++;
        end
        lit("t6_done_cnt", logic'(n_done == 5), 1'b1);
`endif

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", cyc_pass + lit_pass, cyc_chk + lit_chk);
        $finish;
    end

endmodule
